spi_peripheral_controller: RTL and testbench



---
 rtl/spi_pkg.sv | 6 +
 rtl/spi_pin_sync.sv | 18 +
 rtl/sync_fifo.sv | 38 +++
 rtl/spi_peripheral_controller.sv | 97 +++++++++
 tb/tb_spi_peripheral_controller.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI peripheral controller
package spi_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_periph_state_t;
  localparam int SPI_BYTE_W = 8;
  localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE = 8'hFF;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-flop synchronizer plus history flop for one pin (i_pin -> o_val, o_rise, o_fall pulses)
module spi_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_val,
  output logic o_rise,
  output logic o_fall
);
  logic [2:0] r_s;
  // during reset the history flop tracks the pin, so a level held across reset is not seen as an edge
  always_ff @(posedge clk) r_s <= {rst ? r_s[0] : r_s[1], r_s[0], i_pin};
  always_comb begin
    o_val = r_s[1];
    o_rise = r_s[1] & ~r_s[2];
    o_fall = ~r_s[1] & r_s[2];
  end
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO (i_wr/i_din push, i_rd pop, o_dout head, o_empty/o_full); a pop frees room for a same-cycle push when full
module sync_fifo #(
  parameter int ADD_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr,
  input  logic                  i_rd,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_empty,
  output logic                  o_full
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADD_WIDTH];
  logic [ADD_WIDTH-1:0] r_wp, r_rp;
  logic [ADD_WIDTH:0] r_cnt;
  logic w_wr, w_rd;
  always_comb begin
    o_empty = r_cnt == '0;
    o_full = r_cnt[ADD_WIDTH];
    o_dout = r_mem[r_rp];
    w_rd = i_rd & ~o_empty;
    w_wr = i_wr & (~o_full | w_rd);
  end
  always_ff @(posedge clk) if (w_wr) r_mem[r_wp] <= i_din;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + ADD_WIDTH'(1);
      if (w_rd) r_rp <= r_rp + ADD_WIDTH'(1);
      r_cnt <= r_cnt + (ADD_WIDTH+1)'(w_wr) - (ADD_WIDTH+1)'(w_rd);
    end
  end
endmodule

// File: rtl/spi_peripheral_controller.sv
// spi_peripheral_controller: SPI mode-0 responder; CPU side i_wr/i_din/i_rd/o_dout plus FIFO status and sticky errors, pins i_spi_sck/i_spi_cs_n/i_spi_mosi -> o_spi_miso/o_spi_miso_oe
module spi_peripheral_controller
  import spi_pkg::*;
#(
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE = SPI_IDLE_BYTE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr,
  input  logic [SPI_BYTE_W-1:0] i_din,
  input  logic                  i_rd,
  output logic [SPI_BYTE_W-1:0] o_dout,
  output logic                  o_data_avail,
  output logic                  o_tx_empty,
  output logic                  o_tx_full,
  output logic                  o_rx_overrun,
  output logic                  o_tx_underrun,
  input  logic                  i_clr_err,
  input  logic                  i_spi_sck,
  input  logic                  i_spi_cs_n,
  input  logic                  i_spi_mosi,
  output logic                  o_spi_miso,
  output logic                  o_spi_miso_oe
);
  spi_periph_state_t r_state, w_state_nxt;
  logic [SPI_BYTE_W-1:0] r_tx_sh, r_rx_sh, r_push_data, r_dout, w_tx_head, w_rx_head, w_tx_byte;
  logic [2:0] r_bit_cnt;
  logic r_push, r_miso, r_oe, r_ovr, r_und;
  logic w_sck_val, w_sck_rise, w_sck_fall, w_cs_val, w_cs_rise, w_cs_fall, w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_shift, w_load, w_tx_pop, w_rx_rd, w_rx_empty, w_rx_full, w_rx_drop, w_unused;
  spi_pin_sync u_sck (.clk(clk), .rst(rst), .i_pin(i_spi_sck), .o_val(w_sck_val), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  spi_pin_sync u_cs (.clk(clk), .rst(rst), .i_pin(i_spi_cs_n), .o_val(w_cs_val), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
  spi_pin_sync u_mosi (.clk(clk), .rst(rst), .i_pin(i_spi_mosi), .o_val(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));
  sync_fifo #(.ADD_WIDTH(FIFO_ADDR_WIDTH), .DATA_WIDTH(SPI_BYTE_W)) u_tx (
    .clk(clk), .rst(rst), .i_wr(i_wr), .i_rd(w_tx_pop), .i_din(i_din),
    .o_dout(w_tx_head), .o_empty(o_tx_empty), .o_full(o_tx_full)
  );
  sync_fifo #(.ADD_WIDTH(FIFO_ADDR_WIDTH), .DATA_WIDTH(SPI_BYTE_W)) u_rx (
    .clk(clk), .rst(rst), .i_wr(r_push), .i_rd(w_rx_rd), .i_din(r_push_data),
    .o_dout(w_rx_head), .o_empty(w_rx_empty), .o_full(w_rx_full)
  );
  always_comb begin
    w_state_nxt = w_cs_rise ? IDLE : (r_state == IDLE) ? (w_cs_fall ? LOAD : IDLE) : SHIFT;
    w_shift = ~w_cs_rise & (r_state == SHIFT);
    // a fall at bit_cnt 0 is a byte boundary: fetch the next reply byte exactly like LOAD
    w_load = ~w_cs_rise & ((r_state == LOAD) | (w_shift & w_sck_fall & (r_bit_cnt == 3'd0)));
    w_tx_byte = o_tx_empty ? IDLE_BYTE : w_tx_head;
    w_tx_pop = w_load & ~o_tx_empty;
    w_rx_rd = i_rd & ~w_rx_empty;
    w_rx_drop = r_push & w_rx_full & ~w_rx_rd;
    w_unused = ^{w_sck_val, w_cs_val, w_mosi_rise, w_mosi_fall};
    o_dout = r_dout;
    o_data_avail = ~w_rx_empty;
    o_rx_overrun = r_ovr;
    o_tx_underrun = r_und;
    o_spi_miso = r_miso;
    o_spi_miso_oe = r_oe;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_sh <= '0;
      r_rx_sh <= '0;
      r_push_data <= '0;
      r_dout <= '0;
      r_bit_cnt <= '0;
      r_push <= 1'b0;
      r_miso <= 1'b0;
      r_oe <= 1'b0;
      r_ovr <= 1'b0;
      r_und <= 1'b0;
    end else begin
      r_push <= w_shift & w_sck_rise & (r_bit_cnt == 3'd7);
      r_push_data <= {r_rx_sh[6:0], w_mosi};
      r_ovr <= (r_ovr & ~i_clr_err) | w_rx_drop;
      r_und <= (r_und & ~i_clr_err) | (w_load & o_tx_empty);
      r_oe <= w_cs_rise ? 1'b0 : (r_state == LOAD) ? 1'b1 : r_oe;
      if (w_rx_rd) r_dout <= w_rx_head;
      if (w_load) begin
        r_tx_sh <= w_tx_byte;
        r_miso <= w_tx_byte[7];
      end else if (w_shift & w_sck_fall) begin
        r_tx_sh <= {r_tx_sh[6:0], 1'b0};
        r_miso <= r_tx_sh[6];
      end
      if (w_cs_rise | (r_state == LOAD)) r_bit_cnt <= '0;
      else if (w_shift & w_sck_rise) begin
        r_rx_sh <= {r_rx_sh[6:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_spi_peripheral_controller.sv
// tb_spi_peripheral_controller: table vectors, corner sequences and random frames checked against a byte-level model
module tb_spi_peripheral_controller;
  logic clk = 0, rst = 1, wr = 0, rd = 0, clr_err = 0, sck = 0, cs_n = 1, mosi = 0;
  logic [7:0] din = 0, dout;
  logic data_avail, tx_empty, tx_full, rx_overrun, tx_underrun, miso, miso_oe;
  int n_run = 0, n_fail = 0;
  logic [7:0] m_tx[$], m_rx[$];
  logic m_und = 0, m_ovr = 0;
  typedef struct {
    int npre; logic [7:0] pre0, pre1; logic [31:0] mosi; int nbits;
    logic [31:0] miso; int nrx; logic [7:0] rx0, rx1; logic und;
  } vec_t;
  vec_t vt[4];

  spi_peripheral_controller dut (
    .clk(clk), .rst(rst), .i_wr(wr), .i_din(din), .i_rd(rd), .o_dout(dout),
    .o_data_avail(data_avail), .o_tx_empty(tx_empty), .o_tx_full(tx_full),
    .o_rx_overrun(rx_overrun), .o_tx_underrun(tx_underrun), .i_clr_err(clr_err),
    .i_spi_sck(sck), .i_spi_cs_n(cs_n), .i_spi_mosi(mosi),
    .o_spi_miso(miso), .o_spi_miso_oe(miso_oe)
  );

  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic tb_push(input logic [7:0] b);
    din = b; wr = 1; step(1); wr = 0;
    if (m_tx.size() < 16) m_tx.push_back(b);
  endtask

  task automatic clr_flags();
    clr_err = 1; step(1); clr_err = 0;
    m_und = 0; m_ovr = 0;
  endtask

  task automatic m_load(output logic [7:0] b);
    if (m_tx.size() != 0) b = m_tx.pop_front();
    else begin b = 8'hFF; m_und = 1; end
  endtask

  // byte-level reference: one fetch per started byte, MSB first out, complete bytes in
  task automatic m_frame(input logic [31:0] mo, input int nbits, output logic [31:0] exp);
    int nl;
    logic [7:0] b;
    nl = (nbits == 0) ? 1 : (nbits + 7) / 8;
    exp = 0;
    for (int k = 0; k < nl; k++) begin
      m_load(b);
      for (int j = 7; j >= 0; j--) if (k * 8 + 7 - j < nbits) exp = {exp[30:0], b[j]};
    end
    for (int k = 0; k < nbits / 8; k++) begin
      b = 8'(mo >> (nbits - 8 * (k + 1)));
      if (m_rx.size() < 16) m_rx.push_back(b);
      else m_ovr = 1;
    end
  endtask

  // host: mode 0, 6-clk half periods; cs_n rises while sck is still high after the last bit
  task automatic frame(input logic [31:0] mo, input int nbits, output logic [31:0] got);
    got = 0;
    cs_n = 0; step(8);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = mo[i]; step(6);
      got = {got[30:0], miso}; sck = 1; step(6);
      if (i != 0) sck = 0;
    end
    cs_n = 1; step(6); sck = 0; step(8);
  endtask

  task automatic run_frame(input logic [31:0] mo, input int nbits, input string nm);
    logic [31:0] got, exp;
    m_frame(mo, nbits, exp);
    frame(mo, nbits, got);
    chk(nm, got & ((32'd1 << nbits) - 1), exp);
  endtask

  task automatic drain(input string nm);
    chk({nm, "_avail"}, data_avail, m_rx.size() != 0);
    while (m_rx.size() != 0) begin
      rd = 1; step(1); rd = 0;
      chk(nm, dout, m_rx.pop_front());
    end
    chk({nm, "_drained"}, data_avail, 0);
  endtask

  task automatic flags(input string nm);
    chk({nm, "_und"}, tx_underrun, m_und);
    chk({nm, "_ovr"}, rx_overrun, m_ovr);
    chk({nm, "_tx_empty"}, tx_empty, m_tx.size() == 0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_dout"}, dout, 0);
    chk({nm, "_miso"}, miso, 0);
    chk({nm, "_oe"}, miso_oe, 0);
    chk({nm, "_ovr"}, rx_overrun, 0);
    chk({nm, "_und"}, tx_underrun, 0);
    chk({nm, "_avail"}, data_avail, 0);
    chk({nm, "_tx_empty"}, tx_empty, 1);
    chk({nm, "_tx_full"}, tx_full, 0);
  endtask

  initial begin
    logic [31:0] got, exp;
    int nb;
    vt[0] = '{2, 8'hA5, 8'h3C, 32'h1234, 16, 32'hA53C, 2, 8'h12, 8'h34, 1'b0};
    vt[1] = '{0, 8'h00, 8'h00, 32'h5A, 8, 32'hFF, 1, 8'h5A, 8'h00, 1'b1};
    vt[2] = '{1, 8'h81, 8'h00, 32'h16, 5, 32'h10, 0, 8'h00, 8'h00, 1'b0};
    vt[3] = '{1, 8'h77, 8'h00, 32'hC3E1, 16, 32'h77FF, 2, 8'hC3, 8'hE1, 1'b1};
    step(4); rst = 0; step(2);
    chk_reset("reset");

    for (int i = 0; i < 4; i++) begin
      if (vt[i].npre > 0) tb_push(vt[i].pre0);
      if (vt[i].npre > 1) tb_push(vt[i].pre1);
      m_frame(vt[i].mosi, vt[i].nbits, exp);
      frame(vt[i].mosi, vt[i].nbits, got);
      chk($sformatf("vec%0d_miso", i), got & ((32'd1 << vt[i].nbits) - 1), vt[i].miso);
      chk($sformatf("vec%0d_avail", i), data_avail, vt[i].nrx != 0);
      for (int k = 0; k < vt[i].nrx; k++) begin
        rd = 1; step(1); rd = 0;
        chk($sformatf("vec%0d_rx%0d", i, k), dout, k == 0 ? vt[i].rx0 : vt[i].rx1);
        void'(m_rx.pop_front());
      end
      chk($sformatf("vec%0d_empty", i), data_avail, 0);
      chk($sformatf("vec%0d_tx_empty", i), tx_empty, 1);
      chk($sformatf("vec%0d_und", i), tx_underrun, vt[i].und);
      chk($sformatf("vec%0d_ovr", i), rx_overrun, 0);
      clr_flags();
      chk($sformatf("vec%0d_und_clr", i), tx_underrun, 0);
    end

    for (int k = 0; k < 17; k++) run_frame(32'(k), 8, "ovf_miso");
    chk("ovf_flag", rx_overrun, 1);
    flags("ovf");
    drain("ovf_rx");
    clr_flags();

    run_frame(32'h1B, 5, "abort_miso");
    chk("abort_oe_between", miso_oe, 0);
    run_frame(32'hC3, 8, "abort_c3_miso");
    chk("abort_oe_after", miso_oe, 0);
    drain("abort_rx");
    clr_flags();

    tb_push(8'h5C);
    cs_n = 1;
    for (int k = 0; k < 4; k++) begin
      sck = 1; step(6); sck = 0; step(6);
      chk("csh_oe", miso_oe, 0);
    end
    chk("csh_avail", data_avail, 0);
    flags("csh");

    for (int k = 0; k < 16; k++) tb_push(8'(8'h60 + k));
    chk("txfull", tx_full, 1);
    run_frame(32'hE7, 8, "txfull_miso");
    chk("txfull_after", tx_full, 0);
    drain("txfull_rx");
    flags("txfull");
    clr_flags();

    for (int r = 0; r < 20; r++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) tb_push(8'($urandom));
      nb = $urandom_range(1, 24);
      run_frame($urandom & ((32'd1 << nb) - 1), nb, "rnd_miso");
      flags("rnd");
      if ($urandom_range(0, 1) == 1) drain("rnd_rx");
      if ($urandom_range(0, 2) == 0) clr_flags();
    end

    run_frame(32'h4D, 8, "pre_rst");
    tb_push(8'h11); tb_push(8'h22);
    cs_n = 0; step(8);
    for (int k = 0; k < 3; k++) begin
      mosi = 1; step(6); sck = 1; step(6); sck = 0;
    end
    step(2); rst = 1; step(2); rst = 0; step(1);
    m_tx.delete(); m_rx.delete(); m_und = 0; m_ovr = 0;
    chk_reset("midrst");
    cs_n = 1; step(8);
    chk("midrst_idle_oe", miso_oe, 0);
    chk("midrst_no_rx", data_avail, 0);
    tb_push(8'h3A);
    run_frame(32'h96, 8, "post_rst_miso");
    drain("post_rst_rx");
    flags("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
